pipelined_csel_adder: RTL

PIPELINED_CSEL_ADDER -- requirements
Module: pipelined_csel_adder

---
 rtl/csel_pkg.sv | 21 ++
 rtl/csel_block.sv | 42 ++++
 rtl/pipelined_csel_adder.sv | 111 +++++++++++
 3 files changed

// File: rtl/csel_pkg.sv
// Shared defaults and the per-stage pipeline record for the carry-select adder.
// Data fields are sized to the default width; narrower instances zero-extend.
package csel_pkg;

   localparam int CSEL_WIDTH = 32;
   localparam int CSEL_BLOCK = 8;

   // a_rem/b_rem hold operand bits not yet consumed, already shifted so the next
   // block's bits sit at [BLOCK-1:0]; b_rem is the effective (possibly inverted) B.
   typedef struct packed {
      logic                  valid;
      logic                  carry;
      logic                  sub;
      logic                  a_msb;
      logic                  b_msb;
      logic [CSEL_WIDTH-1:0] psum;
      logic [CSEL_WIDTH-1:0] a_rem;
      logic [CSEL_WIDTH-1:0] b_rem;
   } stage_rec_t;

endpackage

// File: rtl/csel_block.sv
// One carry-select slice: two ripple adders (carry-in 0 and 1) in parallel,
// with the incoming carry choosing the sum and the carry-out.
module csel_block
   import csel_pkg::*;
#(
   parameter int BLOCK = CSEL_BLOCK
) (
   input  logic [BLOCK-1:0] a_i,
   input  logic [BLOCK-1:0] b_i,
   input  logic             cin_i,
   output logic [BLOCK-1:0] sum_o,
   output logic             cout_o
);

   logic [BLOCK-1:0] p;
   logic [BLOCK-1:0] g;
   logic [BLOCK-1:0] s0;
   logic [BLOCK-1:0] s1;
   logic [BLOCK:0]   c0;
   logic [BLOCK:0]   c1;

   assign p = a_i ^ b_i;
   assign g = a_i & b_i;

   always_comb begin
      c0    = '0;
      c1    = '0;
      s0    = '0;
      s1    = '0;
      c1[0] = 1'b1;
      for (int i = 0; i < BLOCK; i++) begin
         s0[i]   = p[i] ^ c0[i];
         c0[i+1] = g[i] | (p[i] & c0[i]);
         s1[i]   = p[i] ^ c1[i];
         c1[i+1] = g[i] | (p[i] & c1[i]);
      end
   end

   assign sum_o  = cin_i ? s1 : s0;
   assign cout_o = cin_i ? c1[BLOCK] : c0[BLOCK];

endmodule

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor: one BLOCK-wide slice per stage,
// valid/ready handshake, whole pipeline freezes while the output is stalled.
module pipelined_csel_adder
   import csel_pkg::*;
#(
   parameter int WIDTH = CSEL_WIDTH,
   parameter int BLOCK = CSEL_BLOCK
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NSTG = WIDTH / BLOCK;
   localparam int RW   = CSEL_WIDTH;

   if (BLOCK < 1 || (WIDTH % BLOCK) != 0 || WIDTH > RW) begin : g_bad_cfg
      $error("pipelined_csel_adder: WIDTH must be a multiple of BLOCK and at most %0d", RW);
   end

   logic [RW-1:0]    a_ext;
   logic [RW-1:0]    b_ext;
   logic             cin_eff;
   logic             stall;

   logic [BLOCK-1:0] blk_a  [NSTG];
   logic [BLOCK-1:0] blk_b  [NSTG];
   logic [BLOCK-1:0] blk_s  [NSTG];
   logic             blk_ci [NSTG];
   logic             blk_co [NSTG];

   stage_rec_t       st_q [NSTG];
   stage_rec_t       st_d [NSTG];

   assign a_ext   = RW'(a);
   assign b_ext   = RW'(sub ? ~b : b);
   assign cin_eff = sub | cin;

   assign stall    = st_q[NSTG-1].valid & ~out_ready;
   assign in_ready = ~stall;

   // Stage 0 works straight off the ports; later stages off the previous register.
   for (genvar gi = 0; gi < NSTG; gi++) begin : g_stg
      if (gi == 0) begin : g_first
         assign blk_a[gi]  = a_ext[BLOCK-1:0];
         assign blk_b[gi]  = b_ext[BLOCK-1:0];
         assign blk_ci[gi] = cin_eff;
      end else begin : g_rest
         assign blk_a[gi]  = st_q[gi-1].a_rem[BLOCK-1:0];
         assign blk_b[gi]  = st_q[gi-1].b_rem[BLOCK-1:0];
         assign blk_ci[gi] = st_q[gi-1].carry;
      end

      csel_block #(.BLOCK(BLOCK)) u_blk (
         .a_i    (blk_a[gi]),
         .b_i    (blk_b[gi]),
         .cin_i  (blk_ci[gi]),
         .sum_o  (blk_s[gi]),
         .cout_o (blk_co[gi])
      );
   end

   always_comb begin
      st_d[0]       = '0;
      st_d[0].valid = in_valid;
      st_d[0].carry = blk_co[0];
      st_d[0].sub   = sub;
      st_d[0].a_msb = a[WIDTH-1];
      st_d[0].b_msb = b[WIDTH-1];
      st_d[0].psum  = RW'(blk_s[0]);
      st_d[0].a_rem = a_ext >> BLOCK;
      st_d[0].b_rem = b_ext >> BLOCK;
      for (int k = 1; k < NSTG; k++) begin
         st_d[k]       = st_q[k-1];
         st_d[k].carry = blk_co[k];
         st_d[k].psum  = st_q[k-1].psum | (RW'(blk_s[k]) << (k * BLOCK));
         st_d[k].a_rem = st_q[k-1].a_rem >> BLOCK;
         st_d[k].b_rem = st_q[k-1].b_rem >> BLOCK;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NSTG; k++) begin
            st_q[k] <= '0;
         end
      end else if (!stall) begin
         for (int k = 0; k < NSTG; k++) begin
            st_q[k] <= st_d[k];
         end
      end
   end

   // Raw B sign is kept so the effective sign is recovered with the sub flag.
   assign out_valid = st_q[NSTG-1].valid;
   assign sum       = st_q[NSTG-1].psum[WIDTH-1:0];
   assign cout      = st_q[NSTG-1].carry;
   assign ovf       = (st_q[NSTG-1].a_msb == (st_q[NSTG-1].b_msb ^ st_q[NSTG-1].sub)) &&
                      (st_q[NSTG-1].psum[WIDTH-1] != st_q[NSTG-1].a_msb);

endmodule
